pci_mem_target: RTL and testbench

PCI_MEM_TARGET -- requirements
Module: pci_mem_target

---
 rtl/pci_mem_pkg.sv | 32 +++
 rtl/pci_mem_target_if.sv | 55 +++++
 rtl/pci_mem_wfifo.sv | 71 +++++++
 rtl/pci_mem_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_pci_mem_target.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pci_mem_pkg
//  Description : Shared types and defaults for the PCI memory-window target:
//                FSM state encoding, parameter defaults and write-FIFO entry
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pci_mem_pkg;

    localparam int AW_DEFAULT       = 27;
    localparam int WF_DEPTH_DEFAULT = 8;

    // Write-FIFO entry: {qword address, active-low byte enables, qword data}
    function automatic int wf_entry_width(input int aw);
        return aw - 3 + 8 + 64;
    endfunction

    localparam int WF_ENTRY_W_DEFAULT = AW_DEFAULT - 3 + 8 + 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_BURST = 3'd1,
        ST_WR_FLUSH = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RETRY    = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pci_mem_target_if.sv
`default_nettype none
// ============================================================================
//  Module      : pci_mem_target_if
//  Description : Bundle of the PCI-core slave signals and the DDR request /
//                response signals seen by the memory-window target. The
//                slave modport is the target's view, master the peer's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pci_mem_target_if #(
    parameter int AW = pci_mem_pkg::AW_DEFAULT
);
    import pci_mem_pkg::*;

    // PCI-core slave side
    logic          base_hit;
    logic [31:0]   addr;
    logic [31:0]   adio_out;
    logic          s_wrdn;
    logic          s_data;
    logic          s_data_vld;
    logic [3:0]    s_cbe;
    logic [31:0]   adio_in;
    logic          s_ready;
    logic          s_term;
    logic          s_abort;

    // DDR request side
    logic          ddr_req;
    logic          ddr_write;
    logic [AW-4:0] ddr_addr;
    logic [63:0]   ddr_wdata;
    logic [7:0]    ddr_wbe_n;
    logic          ddr_ack;

    // DDR response side
    logic [63:0]   ddr_rdata;
    logic          ddr_rvalid;
    logic          ddr_not_ready;

    modport slave (
        input  base_hit, addr, adio_out, s_wrdn, s_data, s_data_vld, s_cbe,
        input  ddr_ack, ddr_rdata, ddr_rvalid, ddr_not_ready,
        output adio_in, s_ready, s_term, s_abort,
        output ddr_req, ddr_write, ddr_addr, ddr_wdata, ddr_wbe_n
    );

    modport master (
        output base_hit, addr, adio_out, s_wrdn, s_data, s_data_vld, s_cbe,
        output ddr_ack, ddr_rdata, ddr_rvalid, ddr_not_ready,
        input  adio_in, s_ready, s_term, s_abort,
        input  ddr_req, ddr_write, ddr_addr, ddr_wdata, ddr_wbe_n
    );

endinterface
`default_nettype wire

// File: rtl/pci_mem_wfifo.sv
`default_nettype none
// ============================================================================
//  Module      : pci_mem_wfifo
//  Description : Single-clock synchronous write FIFO with full, almost-full
//                (exactly one free entry) and empty flags. Head entry is
//                presented combinationally on dout_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_mem_wfifo
    import pci_mem_pkg::*;
#(
    parameter int WIDTH = WF_ENTRY_W_DEFAULT,
    parameter int DEPTH = WF_DEPTH_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] din_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push     = push_i & ~full_o;
    assign w_do_pop      = pop_i & ~empty_o;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == (PW+1)'(DEPTH));
    assign almost_full_o = (count_q == (PW+1)'(DEPTH - 1));
    assign dout_o        = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count as is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pci_mem_target.sv
`default_nettype none
// ============================================================================
//  Module      : pci_mem_target
//  Description : PCI memory-window target bridging 32-bit PCI bursts onto a
//                64-bit DDR request port. Writes are assembled into qwords and
//                posted through a FIFO; reads fetch one qword at a time with
//                no prefetch. Retries while the DDR controller initialises.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_mem_target
    import pci_mem_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int WF_DEPTH = WF_DEPTH_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pci_mem_target_if.slave  bus
);

    localparam int CW = AW - 2;               // dword counter width
    localparam int QW = AW - 3;               // qword address width
    localparam int EW = wf_entry_width(AW);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            s_data_q;
    logic            w_fall;

    // Qword assembler
    logic [63:0]     asm_data_q, asm_data_d;
    logic [7:0]      asm_be_q, asm_be_d;
    logic [QW-1:0]   asm_qaddr_q, asm_qaddr_d;
    logic            asm_vld_q, asm_vld_d;

    // Read path
    logic [63:0]     rbuf_q, rbuf_d;
    logic [31:0]     adio_q, adio_d;

    // FIFO hookup
    logic            w_push;
    logic [EW-1:0]   w_push_entry;
    logic            w_pop;
    logic [EW-1:0]   w_head;
    logic            w_full;
    logic            w_afull;
    logic            w_empty;

    // Combinational outputs
    logic            w_s_ready;
    logic            w_s_term;
    logic            w_rd_req;
    logic            w_ddr_req;
    logic            w_ddr_write;
    logic [QW-1:0]   w_ddr_addr;
    logic [63:0]     w_ddr_wdata;
    logic [7:0]      w_ddr_wbe_n;
    logic            w_unused;

    assign w_fall = s_data_q & ~bus.s_data;

    pci_mem_wfifo #(
        .WIDTH (EW),
        .DEPTH (WF_DEPTH)
    ) u_wfifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (w_push),
        .din_i         (w_push_entry),
        .pop_i         (w_pop),
        .dout_o        (w_head),
        .full_o        (w_full),
        .almost_full_o (w_afull),
        .empty_o       (w_empty)
    );

    // Qword assembler: lower half is held, upper half (or end of burst) pushes
    always_comb begin
        asm_data_d   = asm_data_q;
        asm_be_d     = asm_be_q;
        asm_qaddr_d  = asm_qaddr_q;
        asm_vld_d    = asm_vld_q;
        w_push       = 1'b0;
        w_push_entry = {asm_qaddr_q, asm_be_q, asm_data_q};
        if ((state_q == ST_WR_BURST) && bus.s_data_vld) begin
            if (cnt_q[0]) begin
                w_push       = 1'b1;
                w_push_entry = {cnt_q[CW-1:1], bus.s_cbe, asm_be_q[3:0],
                                bus.adio_out, asm_data_q[31:0]};
                asm_data_d   = '0;
                asm_be_d     = 8'hFF;
                asm_vld_d    = 1'b0;
            end else begin
                asm_data_d[31:0] = bus.adio_out;
                asm_be_d[3:0]    = bus.s_cbe;
                asm_qaddr_d      = cnt_q[CW-1:1];
                asm_vld_d        = 1'b1;
            end
        end else if ((state_q == ST_WR_BURST) && w_fall && asm_vld_q) begin
            w_push     = 1'b1;
            asm_data_d = '0;
            asm_be_d   = 8'hFF;
            asm_vld_d  = 1'b0;
        end
    end

    // FSM next-state, dword counter and read-data staging
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rbuf_d    = rbuf_q;
        adio_d    = adio_q;
        w_s_ready = 1'b0;
        w_s_term  = 1'b0;
        w_rd_req  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.base_hit) begin
                    if (bus.ddr_not_ready) begin
                        state_d = ST_RETRY;
                    end else begin
                        cnt_d   = bus.addr[AW-1:2];
                        state_d = bus.s_wrdn ? ST_WR_BURST : ST_RD_REQ;
                    end
                end
            end
            ST_RETRY: begin
                w_s_term = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_WR_BURST: begin
                // Two free entries: one for a completed qword, one spare for
                // the partial qword flushed when the burst ends
                w_s_ready = ~w_full & ~w_afull;
                if (bus.s_data_vld) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (w_fall) begin
                    state_d = ST_WR_FLUSH;
                end
            end
            ST_WR_FLUSH: begin
                if (!asm_vld_q && w_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                w_rd_req = 1'b1;
                if (w_fall) begin
                    state_d = ST_IDLE;
                end else if (bus.ddr_ack) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (w_fall) begin
                    state_d = ST_IDLE;
                end else if (bus.ddr_rvalid) begin
                    rbuf_d  = bus.ddr_rdata;
                    adio_d  = cnt_q[0] ? bus.ddr_rdata[63:32] : bus.ddr_rdata[31:0];
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                w_s_ready = 1'b1;
                if (w_fall) begin
                    state_d = ST_IDLE;
                end else if (bus.s_data_vld) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q[0]) begin
                        // Leaving this qword: fetch the next one on demand
                        state_d = ST_RD_REQ;
                    end else begin
                        adio_d = rbuf_q[63:32];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DDR request mux: FIFO drain has priority; reads only run with it empty
    always_comb begin
        w_ddr_req   = 1'b0;
        w_ddr_write = 1'b0;
        w_ddr_addr  = '0;
        w_ddr_wdata = '0;
        w_ddr_wbe_n = 8'hFF;
        if (!w_empty) begin
            w_ddr_req   = 1'b1;
            w_ddr_write = 1'b1;
            {w_ddr_addr, w_ddr_wbe_n, w_ddr_wdata} = w_head;
        end else if (w_rd_req) begin
            w_ddr_req  = 1'b1;
            w_ddr_addr = cnt_q[CW-1:1];
        end
    end

    assign w_pop = ~w_empty & bus.ddr_ack;

    // State, counter, assembler and read buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_data_q    <= 1'b0;
            asm_data_q  <= '0;
            asm_be_q    <= 8'hFF;
            asm_qaddr_q <= '0;
            asm_vld_q   <= 1'b0;
            rbuf_q      <= '0;
            adio_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_data_q    <= bus.s_data;
            asm_data_q  <= asm_data_d;
            asm_be_q    <= asm_be_d;
            asm_qaddr_q <= asm_qaddr_d;
            asm_vld_q   <= asm_vld_d;
            rbuf_q      <= rbuf_d;
            adio_q      <= adio_d;
        end
    end

    assign bus.adio_in   = adio_q;
    assign bus.s_ready   = w_s_ready;
    assign bus.s_term    = w_s_term;
    assign bus.s_abort   = 1'b0;
    assign bus.ddr_req   = w_ddr_req;
    assign bus.ddr_write = w_ddr_write;
    assign bus.ddr_addr  = w_ddr_addr;
    assign bus.ddr_wdata = w_ddr_wdata;
    assign bus.ddr_wbe_n = w_ddr_wbe_n;

    // Address bits outside the window and the byte offset are not decoded
    assign w_unused = ^bus.addr;

endmodule
`default_nettype wire

// File: tb/tb_pci_mem_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_mem_target
//  Description : Self-checking bench for pci_mem_target. A DDR model acks
//                requests and pops expected transactions from scoreboard
//                queues; per-feature tasks drive PCI-side stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_mem_target;

    localparam int AW = 27;

    typedef struct {
        logic [AW-4:0] qaddr;
        logic [7:0]    be_n;
        logic [63:0]   data;
        logic [63:0]   mask;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pci_mem_target_if #(.AW(AW)) bus ();

    pci_mem_target #(
        .AW       (AW),
        .WF_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_exp_t       exp_wr_q[$];
    logic [AW-4:0] exp_rd_addr_q[$];
    logic [63:0]   rd_data_q[$];
    logic [31:0]   exp_adio_q[$];

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          n_wr_seen = 0;
    int          n_req_seen = 0;
    bit          ack_en    = 1'b0;
    int          rd_delay  = 0;
    logic [63:0] rd_next   = '0;

    function automatic logic [31:0] dword_pat(input logic [31:0] a, input int i);
        return (a ^ 32'hA5C3_0000) + 32'(i) * 32'h0101_0101;
    endfunction

    // DDR model: acks every request and checks it against the scoreboard
    initial begin : ddr_model
        wr_exp_t e;
        forever begin
            @(negedge clk);
            bus.ddr_ack    = 1'b0;
            bus.ddr_rvalid = 1'b0;
            if (!rst && bus.ddr_req) n_req_seen++;
            if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) begin
                    bus.ddr_rvalid = 1'b1;
                    bus.ddr_rdata  = rd_next;
                end
            end
            if (!rst && ack_en && bus.ddr_req) begin
                bus.ddr_ack = 1'b1;
                n_cmp++;
                if (bus.ddr_write) begin
                    n_wr_seen++;
                    if (exp_wr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL wr_unexpected: got addr=%h be_n=%h data=%h, required no write",
                                 bus.ddr_addr, bus.ddr_wbe_n, bus.ddr_wdata);
                    end else begin
                        e = exp_wr_q.pop_front();
                        if (bus.ddr_addr !== e.qaddr || bus.ddr_wbe_n !== e.be_n ||
                            (bus.ddr_wdata & e.mask) !== (e.data & e.mask)) begin
                            n_err++;
                            $display("FAIL wr_txn: got addr=%h be_n=%h data=%h, required addr=%h be_n=%h data=%h (mask %h)",
                                     bus.ddr_addr, bus.ddr_wbe_n, bus.ddr_wdata,
                                     e.qaddr, e.be_n, e.data, e.mask);
                        end
                    end
                end else begin
                    if (exp_rd_addr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_unexpected: got addr=%h, required no read", bus.ddr_addr);
                    end else if (bus.ddr_addr !== exp_rd_addr_q[0]) begin
                        n_err++;
                        $display("FAIL rd_addr: got %h, required %h", bus.ddr_addr, exp_rd_addr_q[0]);
                        void'(exp_rd_addr_q.pop_front());
                    end else begin
                        void'(exp_rd_addr_q.pop_front());
                    end
                    rd_next  = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                    rd_delay = 2;
                end
            end
        end
    end

    task automatic pci_write(input logic [31:0] a, input int n, input logic [3:0] cbe,
                             output int accepted);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.base_hit = 1'b1;
        bus.addr     = a;
        bus.s_wrdn   = 1'b1;
        @(negedge clk);
        bus.base_hit = 1'b0;
        bus.s_data   = 1'b1;
        accepted     = 0;
        while (accepted < n && guard < 200) begin
            if (bus.s_ready) begin
                bus.s_data_vld = 1'b1;
                bus.adio_out   = dword_pat(a, accepted);
                bus.s_cbe      = cbe;
                accepted++;
            end else begin
                bus.s_data_vld = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.s_data_vld = 1'b0;
        bus.s_data     = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (exp_wr_q.size() == 0 && !bus.ddr_req) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.adio_in !== 32'h0) begin
            n_err++; $display("FAIL rst_adio_in: got %h, required 0", bus.adio_in);
        end
        n_cmp++;
        if ({bus.s_ready, bus.s_term, bus.s_abort} !== 3'b000) begin
            n_err++; $display("FAIL rst_slave_ctl: got ready/term/abort=%b, required 000",
                              {bus.s_ready, bus.s_term, bus.s_abort});
        end
        n_cmp++;
        if ({bus.ddr_req, bus.ddr_write} !== 2'b00) begin
            n_err++; $display("FAIL rst_ddr_ctl: got req/write=%b, required 00", {bus.ddr_req, bus.ddr_write});
        end
        n_cmp++;
        if (bus.ddr_addr !== '0 || bus.ddr_wdata !== 64'h0) begin
            n_err++; $display("FAIL rst_ddr_addr_data: got addr=%h data=%h, required 0/0", bus.ddr_addr, bus.ddr_wdata);
        end
        n_cmp++;
        if (bus.ddr_wbe_n !== 8'hFF) begin
            n_err++; $display("FAIL rst_ddr_wbe_n: got %h, required FF", bus.ddr_wbe_n);
        end
        rst    = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.s_ready !== 1'b0 || bus.ddr_req !== 1'b0) begin
            n_err++; $display("FAIL post_rst_idle: got ready=%b req=%b, required 0/0", bus.s_ready, bus.ddr_req);
        end
    endtask

    task automatic test_write4();
        wr_exp_t e;
        int      acc;
        int      base;
        bit      ok;
        base = n_wr_seen;
        for (int q = 0; q < 2; q++) begin
            e.qaddr = 24'h20 + 24'(q);
            e.be_n  = 8'h00;
            e.data  = {dword_pat(32'h100, 2*q+1), dword_pat(32'h100, 2*q)};
            e.mask  = '1;
            exp_wr_q.push_back(e);
        end
        pci_write(32'h100, 4, 4'h0, acc);
        n_cmp++;
        if (acc !== 4) begin
            n_err++; $display("FAIL wr4_accepted: got %0d dwords, required 4", acc);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL wr4_drain: got %0d pending, required 0", exp_wr_q.size());
        end
        n_cmp++;
        if (n_wr_seen - base !== 2) begin
            n_err++; $display("FAIL wr4_count: got %0d ddr writes, required 2", n_wr_seen - base);
        end
    endtask

    task automatic test_write_single();
        wr_exp_t e;
        int      acc;
        int      base;
        bit      ok;
        base    = n_wr_seen;
        e.qaddr = 24'h20;
        e.be_n  = 8'hCF;
        e.data  = {dword_pat(32'h104, 0), 32'h0};
        e.mask  = 64'hFFFF_FFFF_0000_0000;
        exp_wr_q.push_back(e);
        pci_write(32'h104, 1, 4'b1100, acc);
        wait_idle(ok);
        n_cmp++;
        if (!ok || n_wr_seen - base !== 1) begin
            n_err++; $display("FAIL wr1_count: got %0d ddr writes (drained=%0b), required 1", n_wr_seen - base, ok);
        end
    endtask

    task automatic test_write_wrap();
        wr_exp_t e;
        int      acc;
        int      base;
        bit      ok;
        base    = n_wr_seen;
        e.qaddr = 24'hFF_FFFF;
        e.be_n  = 8'h0F;
        e.data  = {dword_pat(32'h07FF_FFFC, 0), 32'h0};
        e.mask  = 64'hFFFF_FFFF_0000_0000;
        exp_wr_q.push_back(e);
        e.qaddr = 24'h0;
        e.be_n  = 8'hF0;
        e.data  = {32'h0, dword_pat(32'h07FF_FFFC, 1)};
        e.mask  = 64'h0000_0000_FFFF_FFFF;
        exp_wr_q.push_back(e);
        pci_write(32'h07FF_FFFC, 2, 4'h0, acc);
        wait_idle(ok);
        n_cmp++;
        if (!ok || acc !== 2 || n_wr_seen - base !== 2) begin
            n_err++; $display("FAIL wrap_count: got %0d writes, %0d dwords, required 2/2", n_wr_seen - base, acc);
        end
    endtask

    task automatic test_read3();
        logic [31:0] e;
        int          got;
        int          guard;
        bit          saw_low;
        exp_rd_addr_q.push_back(24'h0);
        exp_rd_addr_q.push_back(24'h1);
        rd_data_q.push_back(64'h1111_2222_3333_4444);
        rd_data_q.push_back(64'h5555_6666_7777_8888);
        exp_adio_q.push_back(32'h3333_4444);
        exp_adio_q.push_back(32'h1111_2222);
        exp_adio_q.push_back(32'h7777_8888);
        @(negedge clk);
        bus.base_hit = 1'b1;
        bus.addr     = 32'h0;
        bus.s_wrdn   = 1'b0;
        @(negedge clk);
        bus.base_hit = 1'b0;
        bus.s_data   = 1'b1;
        got = 0; guard = 0; saw_low = 1'b0;
        while (got < 3 && guard < 200) begin
            if (bus.s_ready) begin
                e = exp_adio_q.pop_front();
                n_cmp++;
                if (bus.adio_in !== e) begin
                    n_err++; $display("FAIL rd_adio[%0d]: got %h, required %h", got, bus.adio_in, e);
                end
                bus.s_data_vld = 1'b1;
                got++;
            end else begin
                bus.s_data_vld = 1'b0;
                if (got == 2) saw_low = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        bus.s_data_vld = 1'b0;
        bus.s_data     = 1'b0;
        n_cmp++;
        if (got !== 3) begin
            n_err++; $display("FAIL rd_timeout: got %0d dwords, required 3", got);
        end
        n_cmp++;
        if (saw_low !== 1'b1) begin
            n_err++; $display("FAIL rd_ready_gap: got s_ready low seen=%0b, required 1", saw_low);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.s_ready !== 1'b0 || bus.ddr_req !== 1'b0 || exp_rd_addr_q.size() != 0) begin
            n_err++; $display("FAIL rd_end: got ready=%b req=%b pending_reads=%0d, required 0/0/0",
                              bus.s_ready, bus.ddr_req, exp_rd_addr_q.size());
        end
    endtask

    task automatic test_retry();
        int req_before;
        bus.ddr_not_ready = 1'b1;
        req_before = n_req_seen;
        @(negedge clk);
        bus.base_hit = 1'b1;
        bus.addr     = 32'h300;
        bus.s_wrdn   = 1'b1;
        @(negedge clk);
        bus.base_hit = 1'b0;
        n_cmp++;
        if ({bus.s_term, bus.s_ready} !== 2'b10) begin
            n_err++; $display("FAIL retry_term: got term/ready=%b, required 10", {bus.s_term, bus.s_ready});
        end
        @(negedge clk);
        n_cmp++;
        if (bus.s_term !== 1'b0) begin
            n_err++; $display("FAIL retry_one_cycle: got term=%b, required 0", bus.s_term);
        end
        bus.ddr_not_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_req_seen !== req_before) begin
            n_err++; $display("FAIL retry_no_req: got %0d requests, required 0", n_req_seen - req_before);
        end
    endtask

    task automatic test_fill_reset();
        int acc;
        int guard;
        int base_wr;
        int base_req;
        ack_en = 1'b0;
        @(negedge clk);
        bus.base_hit = 1'b1;
        bus.addr     = 32'h200;
        bus.s_wrdn   = 1'b1;
        @(negedge clk);
        bus.base_hit = 1'b0;
        bus.s_data   = 1'b1;
        acc = 0; guard = 0;
        while (bus.s_ready && acc < 20 && guard < 100) begin
            bus.s_data_vld = 1'b1;
            bus.adio_out   = dword_pat(32'h200, acc);
            bus.s_cbe      = 4'h0;
            acc++;
            @(negedge clk);
            guard++;
        end
        bus.s_data_vld = 1'b0;
        n_cmp++;
        if (acc !== 14) begin
            n_err++; $display("FAIL fill_ready_drop: got %0d dwords before s_ready low, required 14", acc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.ddr_req !== 1'b1 || bus.ddr_addr !== 24'h40 || bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL fill_req_held: got req=%b addr=%h ready=%b, required 1/40/0",
                              bus.ddr_req, bus.ddr_addr, bus.s_ready);
        end
        #2;
        rst        = 1'b1;
        bus.s_data = 1'b0;
        #1;
        n_cmp++;
        if (bus.ddr_req !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_async_req: got req=%b ready=%b, required 0/0", bus.ddr_req, bus.s_ready);
        end
        @(negedge clk);
        rst      = 1'b0;
        ack_en   = 1'b1;
        base_wr  = n_wr_seen;
        base_req = n_req_seen;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_req_seen !== base_req || n_wr_seen !== base_wr) begin
            n_err++; $display("FAIL rst_discard: got %0d requests after reset, required 0", n_req_seen - base_req);
        end
    endtask

    initial begin : main
        bus.base_hit      = 1'b0;
        bus.addr          = 32'h0;
        bus.adio_out      = 32'h0;
        bus.s_wrdn        = 1'b0;
        bus.s_data        = 1'b0;
        bus.s_data_vld    = 1'b0;
        bus.s_cbe         = 4'hF;
        bus.ddr_ack       = 1'b0;
        bus.ddr_rdata     = 64'h0;
        bus.ddr_rvalid    = 1'b0;
        bus.ddr_not_ready = 1'b0;
        test_reset();
        test_write4();
        test_write_single();
        test_write_wrap();
        test_read3();
        test_retry();
        test_fill_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
